// File: rtl/vga_fb_scanout.sv
// VGA scan-out: 640x480 timing counters, framebuffer index fetch, palette RGB capture
// and delay-matched sync/blank, all advancing on pix_en ticks.
module vga_fb_scanout #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int SCALE_LOG2 = 2,
  parameter int ADDR_W     = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_rd,
  input  logic [3:0]        fb_data,
  output logic [3:0]        color_idx,
  input  logic [23:0]       rgb_in,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [H_W-1:0] H_VIS    = H_W'(H_ACTIVE);
  localparam logic [H_W-1:0] HS_FIRST = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_VIS    = V_W'(V_ACTIVE);
  localparam logic [V_W-1:0] VS_FIRST = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [ADDR_W-1:0] CELLS_PER_ROW = ADDR_W'(H_ACTIVE >> SCALE_LOG2);

  logic [H_W-1:0] h_q, h_d;
  logic [V_W-1:0] v_q, v_d;
  logic           act_s1_q, act_s1_d, hs_s1_q, hs_s1_d, vs_s1_q, vs_s1_d;
  logic [3:0]     color_idx_q, color_idx_d;
  logic           act_s2_q, act_s2_d, hs_s2_q, hs_s2_d, vs_s2_q, vs_s2_d;
  logic [23:0]    rgb_q, rgb_d;
  logic           hs_s3_q, hs_s3_d, vs_s3_q, vs_s3_d, blank_n_q, blank_n_d;
  logic           frame_start_q, frame_start_d;

  logic h_end, v_end, active, hs_raw, vs_raw;

  always_comb begin
    h_end  = (h_q == H_LAST);
    v_end  = (v_q == V_LAST);
    active = (h_q < H_VIS) && (v_q < V_VIS);
    hs_raw = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    vs_raw = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));
  end

  // Address truncation to ADDR_W is intended; arithmetic is done at that width.
  always_comb begin
    fb_rd   = pix_en && active && rst_n;
    fb_addr = '0;
    if (active) begin
      fb_addr = ADDR_W'(v_q >> SCALE_LOG2) * CELLS_PER_ROW + ADDR_W'(h_q >> SCALE_LOG2);
    end
  end

  always_comb begin
    h_d           = h_q;
    v_d           = v_q;
    act_s1_d      = act_s1_q;
    hs_s1_d       = hs_s1_q;
    vs_s1_d       = vs_s1_q;
    color_idx_d   = color_idx_q;
    act_s2_d      = act_s2_q;
    hs_s2_d       = hs_s2_q;
    vs_s2_d       = vs_s2_q;
    rgb_d         = rgb_q;
    hs_s3_d       = hs_s3_q;
    vs_s3_d       = vs_s3_q;
    blank_n_d     = blank_n_q;
    frame_start_d = pix_en && h_end && v_end;
    if (pix_en) begin
      h_d = h_end ? '0 : h_q + H_W'(1);
      if (h_end) begin
        v_d = v_end ? '0 : v_q + V_W'(1);
      end
      act_s1_d    = active;
      hs_s1_d     = hs_raw;
      vs_s1_d     = vs_raw;
      // RAM data for the pixel registered in S1 is valid now.
      color_idx_d = act_s1_q ? fb_data : 4'h0;
      act_s2_d    = act_s1_q;
      hs_s2_d     = hs_s1_q;
      vs_s2_d     = vs_s1_q;
      rgb_d       = act_s2_q ? rgb_in : 24'h0;
      hs_s3_d     = hs_s2_q;
      vs_s3_d     = vs_s2_q;
      blank_n_d   = act_s2_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_q           <= '0;
      v_q           <= '0;
      act_s1_q      <= 1'b0;
      hs_s1_q       <= 1'b1;
      vs_s1_q       <= 1'b1;
      color_idx_q   <= 4'h0;
      act_s2_q      <= 1'b0;
      hs_s2_q       <= 1'b1;
      vs_s2_q       <= 1'b1;
      rgb_q         <= 24'h0;
      hs_s3_q       <= 1'b1;
      vs_s3_q       <= 1'b1;
      blank_n_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      h_q           <= h_d;
      v_q           <= v_d;
      act_s1_q      <= act_s1_d;
      hs_s1_q       <= hs_s1_d;
      vs_s1_q       <= vs_s1_d;
      color_idx_q   <= color_idx_d;
      act_s2_q      <= act_s2_d;
      hs_s2_q       <= hs_s2_d;
      vs_s2_q       <= vs_s2_d;
      rgb_q         <= rgb_d;
      hs_s3_q       <= hs_s3_d;
      vs_s3_q       <= vs_s3_d;
      blank_n_q     <= blank_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign color_idx   = color_idx_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = hs_s3_q;
  assign vga_vs      = vs_s3_q;
  assign vga_blank_n = blank_n_q;
  assign frame_start = frame_start_q;

endmodule
